// File: rtl/vend_sequencer_if.sv
// Coin-slot, brewer and change-hopper signal bundle for the vending transaction controller.
// slave = the sequencer itself, master = the surrounding coin decoder / brewer / hopper.
interface vend_sequencer_if #(
  parameter int CREDIT_W = 4
);
  logic                coin_valid;
  logic [1:0]          coin_val;
  logic                cancel;
  logic                coin_accept;
  logic                coin_reject;
  logic                brew_req;
  logic                brew_ack;
  logic                brew_done;
  logic                coffee;
  logic                chg_req;
  logic                chg_ack;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  logic                timeout_refund;

  modport slave (
    input  coin_valid, coin_val, cancel, brew_ack, brew_done, chg_ack,
    output coin_accept, coin_reject, brew_req, coffee, chg_req, credit, busy, timeout_refund
  );

  modport master (
    output coin_valid, coin_val, cancel, brew_ack, brew_done, chg_ack,
    input  coin_accept, coin_reject, brew_req, coffee, chg_req, credit, busy, timeout_refund
  );
endinterface

// File: rtl/vend_sequencer.sv
// Coffee vending transaction controller: coin credit, brew handshake, 25p change payout.
// Optional idle auto-refund in COLLECT is enabled by defining TIMEOUT_REFUND_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no transaction, credit 0
// ST_COLLECT | accepting coins until credit reaches the price
// ST_BREW_REQ| brew_req held until the brewer acknowledges
// ST_BREWING | price deducted, waiting for brew_done
// ST_CHANGE  | paying remaining credit out one 25p coin per chg_ack
module vend_sequencer #(
  parameter int PRICE_UNITS = 4,
  parameter int MAX_CREDIT  = 7,
  parameter int CREDIT_W    = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic            clk,
  input  logic            rst,
  vend_sequencer_if.slave bus
);

  if (PRICE_UNITS < 1 || PRICE_UNITS > MAX_CREDIT) begin : g_bad_price
    $error("vend_sequencer: PRICE_UNITS out of range");
  end
  if (MAX_CREDIT >= (1 << CREDIT_W)) begin : g_bad_width
    $error("vend_sequencer: CREDIT_W too narrow for MAX_CREDIT");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("vend_sequencer: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_BREW_REQ,
    ST_BREWING,
    ST_CHANGE
  } state_e;

  localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_UNITS);
  localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);
  localparam logic [CREDIT_W:0]   ONE_W   = (CREDIT_W+1)'(1);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                coin_accept_q, coin_accept_d;
  logic                coin_reject_q, coin_reject_d;
  logic                coffee_q, coffee_d;
  logic                tmo_q, tmo_d;
  logic [CREDIT_W:0]   coin_sum;
  logic                tmo_hit;

  // Sum one bit wider than credit so an over-limit coin can never wrap into range.
  assign coin_sum = {1'b0, credit_q} + (CREDIT_W+1)'(bus.coin_val) + ONE_W;

`ifdef TIMEOUT_REFUND_EN
  localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q == ST_COLLECT) && (tmo_cnt_q == '0);

  // Down-counter reloads on COLLECT entry and on every accepted coin.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_q != ST_COLLECT && state_d == ST_COLLECT) || coin_accept_d) begin
      tmo_cnt_d = TMO_LOAD;
    end else if (state_q == ST_COLLECT && tmo_cnt_q != '0) begin
      tmo_cnt_d = tmo_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_accept_d = 1'b0;
    coin_reject_d = 1'b0;
    coffee_d      = 1'b0;
    tmo_d         = 1'b0;

    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (state_q == ST_COLLECT && bus.cancel) begin
          state_d       = ST_CHANGE;
          coin_reject_d = bus.coin_valid;
        end else if (bus.coin_valid) begin
          if (coin_sum <= MAX_W) begin
            credit_d      = coin_sum[CREDIT_W-1:0];
            coin_accept_d = 1'b1;
          end else begin
            coin_reject_d = 1'b1;
          end
          state_d = (credit_d >= PRICE_C) ? ST_BREW_REQ : ST_COLLECT;
        end else if (tmo_hit) begin
          state_d = ST_CHANGE;
          tmo_d   = 1'b1;
        end
      end

      ST_BREW_REQ: begin
        coin_reject_d = bus.coin_valid;
        if (bus.brew_ack) begin
          credit_d = credit_q - PRICE_C;
          state_d  = ST_BREWING;
        end
      end

      ST_BREWING: begin
        coin_reject_d = bus.coin_valid;
        if (bus.brew_done) begin
          coffee_d = 1'b1;
          state_d  = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
        end
      end

      ST_CHANGE: begin
        coin_reject_d = bus.coin_valid;
        // A zero-credit refund (cancel with nothing inserted) just falls back to idle.
        if (credit_q == '0) begin
          state_d = ST_IDLE;
        end else if (bus.chg_ack) begin
          credit_d = credit_q - ONE_C;
          if (credit_q == ONE_C) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      coin_accept_q <= 1'b0;
      coin_reject_q <= 1'b0;
      coffee_q      <= 1'b0;
      tmo_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_accept_q <= coin_accept_d;
      coin_reject_q <= coin_reject_d;
      coffee_q      <= coffee_d;
      tmo_q         <= tmo_d;
    end
  end

  assign bus.brew_req       = (state_q == ST_BREW_REQ);
  assign bus.chg_req        = (state_q == ST_CHANGE);
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.credit         = credit_q;
  assign bus.coin_accept    = coin_accept_q;
  assign bus.coin_reject    = coin_reject_q;
  assign bus.coffee         = coffee_q;
  assign bus.timeout_refund = tmo_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer (default price 4 plus a price-6 instance).
// Build with TIMEOUT_REFUND_EN defined to exercise the idle auto-refund path.
module tb_vend_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  vend_sequencer_if #(.CREDIT_W(4)) vif ();
  vend_sequencer_if #(.CREDIT_W(4)) vif6 ();

  vend_sequencer #(
    .PRICE_UNITS(4), .MAX_CREDIT(7), .CREDIT_W(4), .TIMEOUT_CYC(8)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(vif)
  );

  vend_sequencer #(
    .PRICE_UNITS(6), .MAX_CREDIT(7), .CREDIT_W(4), .TIMEOUT_CYC(8)
  ) u_dut6 (
    .clk(clk), .rst(rst), .bus(vif6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vif.coin_valid = 0; vif.coin_val = 0; vif.cancel = 0;
    vif.brew_ack = 0; vif.brew_done = 0; vif.chg_ack = 0;
    vif6.coin_valid = 0; vif6.coin_val = 0; vif6.cancel = 0;
    vif6.brew_ack = 0; vif6.brew_done = 0; vif6.chg_ack = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if (vif.busy !== 1'b0 || vif.credit !== 4'd0 || vif.brew_req !== 1'b0 || vif.chg_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_state busy=%b credit=%0d brew_req=%b chg_req=%b exp all 0",
               vif.busy, vif.credit, vif.brew_req, vif.chg_req);
    end
    checks++;
    if (vif.coin_accept !== 1'b0 || vif.coin_reject !== 1'b0 || vif.coffee !== 1'b0 || vif.timeout_refund !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses accept=%b reject=%b coffee=%b tmo=%b exp all 0",
               vif.coin_accept, vif.coin_reject, vif.coffee, vif.timeout_refund);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_exact_price();
    vif.coin_valid = 1; vif.coin_val = 2'b01;
    step();
    checks++;
    if (vif.credit !== 4'd2 || vif.coin_accept !== 1'b1 || vif.brew_req !== 1'b0) begin
      failures++;
      $display("FAIL t1_first_coin credit=%0d accept=%b brew_req=%b exp 2/1/0", vif.credit, vif.coin_accept, vif.brew_req);
    end
    vif.coin_valid = 0;
    step();
    checks++;
    if (vif.coin_accept !== 1'b0 || vif.busy !== 1'b1) begin
      failures++;
      $display("FAIL t1_accept_pulse accept=%b busy=%b exp 0/1", vif.coin_accept, vif.busy);
    end
    vif.coin_valid = 1; vif.coin_val = 2'b01;
    step();
    checks++;
    if (vif.credit !== 4'd4 || vif.brew_req !== 1'b1) begin
      failures++;
      $display("FAIL t1_second_coin credit=%0d brew_req=%b exp 4/1", vif.credit, vif.brew_req);
    end
    vif.coin_valid = 0; vif.brew_ack = 1;
    step();
    checks++;
    if (vif.credit !== 4'd0 || vif.brew_req !== 1'b0 || vif.busy !== 1'b1) begin
      failures++;
      $display("FAIL t1_ack credit=%0d brew_req=%b busy=%b exp 0/0/1", vif.credit, vif.brew_req, vif.busy);
    end
    vif.brew_ack = 0; vif.brew_done = 1;
    step();
    checks++;
    if (vif.coffee !== 1'b1 || vif.busy !== 1'b0 || vif.chg_req !== 1'b0) begin
      failures++;
      $display("FAIL t1_done coffee=%b busy=%b chg_req=%b exp 1/0/0", vif.coffee, vif.busy, vif.chg_req);
    end
    // brew_done still high in IDLE must be ignored
    step();
    checks++;
    if (vif.coffee !== 1'b0 || vif.busy !== 1'b0) begin
      failures++;
      $display("FAIL t1_done_in_idle coffee=%b busy=%b exp 0/0", vif.coffee, vif.busy);
    end
    vif.brew_done = 0;
  endtask

  task automatic test_change();
    vif.coin_valid = 1; vif.coin_val = 2'b10;
    step();
    step();
    checks++;
    if (vif.credit !== 4'd6 || vif.brew_req !== 1'b1) begin
      failures++;
      $display("FAIL t2_credit credit=%0d brew_req=%b exp 6/1", vif.credit, vif.brew_req);
    end
    vif.coin_valid = 0; vif.brew_ack = 1;
    step();
    checks++;
    if (vif.credit !== 4'd2) begin
      failures++;
      $display("FAIL t2_ack credit=%0d exp 2", vif.credit);
    end
    vif.brew_ack = 0; vif.brew_done = 1;
    step();
    checks++;
    if (vif.coffee !== 1'b1 || vif.chg_req !== 1'b1) begin
      failures++;
      $display("FAIL t2_done coffee=%b chg_req=%b exp 1/1", vif.coffee, vif.chg_req);
    end
    vif.brew_done = 0; vif.chg_ack = 1;
    step();
    checks++;
    if (vif.credit !== 4'd1 || vif.chg_req !== 1'b1) begin
      failures++;
      $display("FAIL t2_chg1 credit=%0d chg_req=%b exp 1/1", vif.credit, vif.chg_req);
    end
    step();
    checks++;
    if (vif.credit !== 4'd0 || vif.chg_req !== 1'b0 || vif.busy !== 1'b0) begin
      failures++;
      $display("FAIL t2_chg2 credit=%0d chg_req=%b busy=%b exp 0/0/0", vif.credit, vif.chg_req, vif.busy);
    end
    vif.chg_ack = 0;
  endtask

  task automatic test_over_limit();
    vif6.coin_valid = 1; vif6.coin_val = 2'b11;
    step();
    vif6.coin_val = 2'b00;
    step();
    checks++;
    if (vif6.credit !== 4'd5 || vif6.coin_accept !== 1'b1 || vif6.brew_req !== 1'b0) begin
      failures++;
      $display("FAIL t3_two_coins credit=%0d accept=%b brew_req=%b exp 5/1/0", vif6.credit, vif6.coin_accept, vif6.brew_req);
    end
    vif6.coin_val = 2'b11;
    step();
    checks++;
    if (vif6.coin_reject !== 1'b1 || vif6.coin_accept !== 1'b0 || vif6.credit !== 4'd5) begin
      failures++;
      $display("FAIL t3_reject reject=%b accept=%b credit=%0d exp 1/0/5", vif6.coin_reject, vif6.coin_accept, vif6.credit);
    end
    vif6.coin_valid = 0;
    apply_reset();
  endtask

  task automatic test_max_boundary();
    vif6.coin_valid = 1; vif6.coin_val = 2'b11;
    step();
    vif6.coin_val = 2'b10;
    step();
    checks++;
    if (vif6.credit !== 4'd7 || vif6.coin_accept !== 1'b1 || vif6.brew_req !== 1'b1) begin
      failures++;
      $display("FAIL max_credit credit=%0d accept=%b brew_req=%b exp 7/1/1", vif6.credit, vif6.coin_accept, vif6.brew_req);
    end
    vif6.coin_valid = 0;
    apply_reset();
  endtask

  task automatic test_cancel();
    vif.coin_valid = 1; vif.coin_val = 2'b10;
    step();
    vif.coin_val = 2'b00; vif.cancel = 1;
    step();
    checks++;
    if (vif.coin_reject !== 1'b1 || vif.coin_accept !== 1'b0 || vif.chg_req !== 1'b1 || vif.credit !== 4'd3) begin
      failures++;
      $display("FAIL t4_cancel reject=%b accept=%b chg_req=%b credit=%0d exp 1/0/1/3",
               vif.coin_reject, vif.coin_accept, vif.chg_req, vif.credit);
    end
    vif.coin_valid = 0; vif.cancel = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (vif.credit !== 4'd3 || vif.chg_req !== 1'b1) begin
        failures++;
        $display("FAIL t4_stall cycle=%0d credit=%0d chg_req=%b exp 3/1", i, vif.credit, vif.chg_req);
      end
    end
    vif.chg_ack = 1;
    repeat (3) step();
    checks++;
    if (vif.credit !== 4'd0 || vif.busy !== 1'b0) begin
      failures++;
      $display("FAIL t4_refund credit=%0d busy=%b exp 0/0", vif.credit, vif.busy);
    end
    vif.chg_ack = 0;
  endtask

  task automatic test_brew_req_ignores();
    vif.coin_valid = 1; vif.coin_val = 2'b11;
    step();
    vif.coin_val = 2'b00; vif.cancel = 1;
    step();
    checks++;
    if (vif.coin_reject !== 1'b1 || vif.brew_req !== 1'b1 || vif.credit !== 4'd4 || vif.chg_req !== 1'b0) begin
      failures++;
      $display("FAIL brew_req_hold reject=%b brew_req=%b credit=%0d chg_req=%b exp 1/1/4/0",
               vif.coin_reject, vif.brew_req, vif.credit, vif.chg_req);
    end
    vif.coin_valid = 0; vif.cancel = 0; vif.brew_ack = 1;
    step();
    vif.brew_ack = 0; vif.brew_done = 1;
    step();
    checks++;
    if (vif.coffee !== 1'b1 || vif.busy !== 1'b0) begin
      failures++;
      $display("FAIL brew_req_vend coffee=%b busy=%b exp 1/0", vif.coffee, vif.busy);
    end
    vif.brew_done = 0;
  endtask

  task automatic test_async_reset();
    vif.coin_valid = 1; vif.coin_val = 2'b10;
    repeat (2) step();
    vif.coin_valid = 0; vif.brew_ack = 1;
    step();
    vif.brew_ack = 0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (vif.busy !== 1'b0 || vif.credit !== 4'd0 || vif.brew_req !== 1'b0) begin
      failures++;
      $display("FAIL t5_async busy=%b credit=%0d brew_req=%b exp 0/0/0", vif.busy, vif.credit, vif.brew_req);
    end
    step();
    rst = 1'b0;
    vif.brew_done = 1; vif.chg_ack = 1;
    step();
    checks++;
    if (vif.coffee !== 1'b0 || vif.busy !== 1'b0 || vif.credit !== 4'd0) begin
      failures++;
      $display("FAIL t5_after coffee=%b busy=%b credit=%0d exp 0/0/0", vif.coffee, vif.busy, vif.credit);
    end
    vif.brew_done = 0; vif.chg_ack = 0;
  endtask

  task automatic test_timeout();
    vif.coin_valid = 1; vif.coin_val = 2'b00;
    step();
    vif.coin_valid = 0;
`ifdef TIMEOUT_REFUND_EN
    repeat (7) step();
    checks++;
    if (vif.timeout_refund !== 1'b0 || vif.chg_req !== 1'b0) begin
      failures++;
      $display("FAIL t6_early tmo=%b chg_req=%b exp 0/0", vif.timeout_refund, vif.chg_req);
    end
    step();
    checks++;
    if (vif.timeout_refund !== 1'b1 || vif.chg_req !== 1'b1 || vif.credit !== 4'd1) begin
      failures++;
      $display("FAIL t6_fire tmo=%b chg_req=%b credit=%0d exp 1/1/1", vif.timeout_refund, vif.chg_req, vif.credit);
    end
    vif.chg_ack = 1;
    step();
    checks++;
    if (vif.timeout_refund !== 1'b0 || vif.credit !== 4'd0 || vif.busy !== 1'b0) begin
      failures++;
      $display("FAIL t6_refund tmo=%b credit=%0d busy=%b exp 0/0/0", vif.timeout_refund, vif.credit, vif.busy);
    end
    vif.chg_ack = 0;
`else
    repeat (20) step();
    checks++;
    if (vif.timeout_refund !== 1'b0 || vif.busy !== 1'b1 || vif.credit !== 4'd1) begin
      failures++;
      $display("FAIL no_timeout tmo=%b busy=%b credit=%0d exp 0/1/1", vif.timeout_refund, vif.busy, vif.credit);
    end
    vif.cancel = 1;
    step();
    vif.cancel = 0; vif.chg_ack = 1;
    step();
    checks++;
    if (vif.credit !== 4'd0 || vif.busy !== 1'b0) begin
      failures++;
      $display("FAIL no_timeout_cancel credit=%0d busy=%b exp 0/0", vif.credit, vif.busy);
    end
    vif.chg_ack = 0;
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    test_reset();
    test_exact_price();
    test_change();
    test_over_limit();
    test_max_boundary();
    test_cancel();
    test_brew_req_ignores();
    test_async_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
